// File: rtl/audio_serial_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : audio_serial_rx
// Purpose  : I2S receiver for one selected channel. Oversamples sck/ws/sd in
//            the clk domain, deserialises WIDTH-bit words MSB first and queues
//            them in a DEPTH-entry show-ahead FIFO drained over rts/rtr.
// Option   : define AUDIO_RX_OVF_COUNT_EN to add ovf_count[7:0], a saturating
//            count of overflow pulses.
// Revision : 1.0 - initial release
// ============================================================================
module audio_serial_rx #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 4,
   parameter int PTR    = 2,
   parameter bit CH_SEL = 1'b0
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             sck,
   input  logic             ws,
   input  logic             sd,
   input  logic             rtr,
   output logic             rts,
   output logic [WIDTH-1:0] aud_out,
   output logic             overflow
`ifdef AUDIO_RX_OVF_COUNT_EN
   ,
   output logic [7:0]       ovf_count
`endif
);

   localparam int               CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);
   localparam logic [PTR:0]     FULL_CNT  = (PTR + 1)'(DEPTH);

   // One-hot receive states
   localparam logic [3:0] S_WAIT_WS = 4'b0001;
   localparam logic [3:0] S_DELAY   = 4'b0010;
   localparam logic [3:0] S_SHIFT   = 4'b0100;
   localparam logic [3:0] S_HOLD    = 4'b1000;

   logic             sck_s1_q, sck_s1_d, sck_s2_q, sck_s2_d, sck_dly_q, sck_dly_d;
   logic             ws_s1_q, ws_s1_d, ws_s2_q, ws_s2_d;
   logic             sd_s1_q, sd_s1_d, sd_s2_q, sd_s2_d;
   logic             ws_q, ws_d;
   logic [3:0]       state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             push_q, push_d;
   logic [PTR-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR:0]     count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   logic sck_rise, ws_edge, match_edge, last_bit;
   logic full, pop, wr_en;

   assign sck_rise   = sck_s2_q & ~sck_dly_q;
   assign ws_edge    = sck_rise & (ws_s2_q != ws_q);
   assign match_edge = ws_edge & (ws_s2_q == CH_SEL);
   assign last_bit   = (bit_cnt_q == LAST_BIT);

   assign rts      = (count_q != '0);
   assign full     = (count_q == FULL_CNT);
   assign pop      = rts & rtr;
   // A full FIFO still accepts a word when a pop frees a slot in the same cycle
   assign wr_en    = push_q & (~full | pop);
   assign overflow = push_q & full & ~pop;
   assign aud_out  = rts ? mem_q[rd_ptr_q] : '0;

   // Synchroniser shifts and the ws value captured at each bit-clock rise
   always_comb begin
      sck_s1_d  = sck;
      sck_s2_d  = sck_s1_q;
      sck_dly_d = sck_s2_q;
      ws_s1_d   = ws;
      ws_s2_d   = ws_s1_q;
      sd_s1_d   = sd;
      sd_s2_d   = sd_s1_q;
      ws_d      = sck_rise ? ws_s2_q : ws_q;
   end

   // Next-state logic; a ws edge always restarts word alignment
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_WAIT_WS, S_HOLD: begin
            if (ws_edge) state_d = match_edge ? S_DELAY : S_WAIT_WS;
         end
         S_DELAY: begin
            if (sck_rise) state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (ws_edge)                   state_d = match_edge ? S_DELAY : S_WAIT_WS;
            else if (sck_rise && last_bit) state_d = S_HOLD;
         end
         default: state_d = S_WAIT_WS;
      endcase
   end

   // Shift register, bit counter and push strobe driven by the current state
   always_comb begin
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      push_d    = 1'b0;
      case (state_q)
         S_DELAY: begin
            if (sck_rise) bit_cnt_d = '0;
         end
         S_SHIFT: begin
            if (sck_rise && !ws_edge) begin
               shreg_d   = {shreg_q[WIDTH-2:0], sd_s2_q};
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               push_d    = last_bit;
            end
         end
         default: ;
      endcase
   end

   // FIFO pointer, occupancy and storage updates
   always_comb begin
      wr_ptr_d = wr_en ? wr_ptr_q + PTR'(1) : wr_ptr_q;
      rd_ptr_d = pop   ? rd_ptr_q + PTR'(1) : rd_ptr_q;
      count_d  = count_q;
      if (wr_en && !pop)      count_d = count_q + (PTR + 1)'(1);
      else if (!wr_en && pop) count_d = count_q - (PTR + 1)'(1);
      mem_d = mem_q;
      if (wr_en) mem_d[wr_ptr_q] = shreg_q;
   end

   // All state registers, cleared asynchronously by rstb
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         sck_s1_q  <= 1'b0;
         sck_s2_q  <= 1'b0;
         sck_dly_q <= 1'b0;
         ws_s1_q   <= 1'b0;
         ws_s2_q   <= 1'b0;
         sd_s1_q   <= 1'b0;
         sd_s2_q   <= 1'b0;
         ws_q      <= 1'b0;
         state_q   <= S_WAIT_WS;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         push_q    <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         sck_s1_q  <= sck_s1_d;
         sck_s2_q  <= sck_s2_d;
         sck_dly_q <= sck_dly_d;
         ws_s1_q   <= ws_s1_d;
         ws_s2_q   <= ws_s2_d;
         sd_s1_q   <= sd_s1_d;
         sd_s2_q   <= sd_s2_d;
         ws_q      <= ws_d;
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         push_q    <= push_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         mem_q     <= mem_d;
      end
   end

`ifdef AUDIO_RX_OVF_COUNT_EN
   logic [7:0] ovf_count_q, ovf_count_d;

   assign ovf_count = ovf_count_q;

   // Saturating tally of dropped samples
   always_comb begin
      ovf_count_d = ovf_count_q;
      if (overflow && ovf_count_q != 8'hFF) ovf_count_d = ovf_count_q + 8'd1;
   end

   // Overflow tally register
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) ovf_count_q <= 8'h00;
      else       ovf_count_q <= ovf_count_d;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_audio_serial_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_audio_serial_rx
// Purpose  : Scoreboard bench for audio_serial_rx. A bit-level I2S driver
//            records every transmitted (ws, sd) bit; the reference model
//            extracts completed words from that history and queues them, and
//            a monitor compares every popped sample against the queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_serial_rx;

   localparam int WIDTH  = 16;
   localparam int DEPTH  = 4;
   localparam int PTR    = 2;
   localparam bit CH_SEL = 1'b0;

   logic             clk  = 1'b0;
   logic             rstb = 1'b0;
   logic             sck  = 1'b0;
   logic             ws   = 1'b0;
   logic             sd   = 1'b0;
   logic             rtr  = 1'b0;
   logic             rts;
   logic [WIDTH-1:0] aud_out;
   logic             overflow;
`ifdef AUDIO_RX_OVF_COUNT_EN
   logic [7:0]       ovf_count;
`endif

   int               checks   = 0;
   int               failures = 0;
   logic [WIDTH-1:0] exp_q[$];
   bit               ws_hist[$];
   bit               sd_hist[$];
   int               ovf_seen = 0;
   int               exp_ovf  = 0;
   bit               rand_rtr = 1'b0;

   always #5 clk = ~clk;

   audio_serial_rx #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .PTR   (PTR),
      .CH_SEL(CH_SEL)
   ) dut (
      .clk      (clk),
      .rstb     (rstb),
      .sck      (sck),
      .ws       (ws),
      .sd       (sd),
      .rtr      (rtr),
      .rts      (rts),
      .aud_out  (aud_out),
      .overflow (overflow)
`ifdef AUDIO_RX_OVF_COUNT_EN
      ,
      .ovf_count(ovf_count)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Advance one clock; inputs change 2 ns after the rising edge
   task automatic tick();
      @(posedge clk);
      #2;
      if (rand_rtr) rtr = 1'($urandom_range(0, 1));
   endtask

   // Reference model: a word completes on bit k when bit i = k-WIDTH-1 starts a
   // run of the selected channel (ws changed there) that lasts through bit k.
   // Bit i+1 is the I2S delay slot; bits i+2..k are the word, MSB first.
   task automatic model_append(input bit w, input bit d, input bit pop_planned);
      int               k;
      int               i;
      bit               prev;
      bit               ok;
      logic [WIDTH-1:0] word;
      ws_hist.push_back(w);
      sd_hist.push_back(d);
      k = ws_hist.size() - 1;
      i = k - (WIDTH + 1);
      if (i < 0) return;
      prev = (i == 0) ? 1'b0 : ws_hist[i-1];
      if (ws_hist[i] != CH_SEL || ws_hist[i] == prev) return;
      ok = 1'b1;
      for (int j = i; j <= k; j++) if (ws_hist[j] != ws_hist[i]) ok = 1'b0;
      if (!ok) return;
      word = '0;
      for (int j = i + 2; j <= k; j++) word = {word[WIDTH-2:0], sd_hist[j]};
      if (exp_q.size() >= DEPTH && !pop_planned) exp_ovf++;
      else exp_q.push_back(word);
   endtask

   // One serial bit: sck low half, then high half (8 clk per sck period).
   // With pulse set, rtr is high only for the edge that writes this word.
   task automatic send_bit(input bit w, input bit d, input bit pulse);
      sck = 1'b0;
      ws  = w;
      sd  = d;
      repeat (4) tick();
      sck = 1'b1;
      model_append(w, d, pulse);
      for (int j = 1; j <= 4; j++) begin
         tick();
         if (pulse && j == 3) rtr = 1'b1;
         if (pulse && j == 4) rtr = 1'b0;
      end
   endtask

   // Frame of nbits with constant ws: edge slot, delay slot, word, padding
   task automatic send_frame(input bit ch, input logic [WIDTH-1:0] word, input int nbits,
                             input bit pulse_last);
      bit d;
      for (int b = 0; b < nbits; b++) begin
         if (b >= 2 && b < WIDTH + 2) d = word[WIDTH+1-b];
         else d = 1'($urandom_range(0, 1));
         send_bit(ch, d, pulse_last && (b == WIDTH + 1));
      end
   endtask

   task automatic send_left(input logic [WIDTH-1:0] word);
      send_frame(1'b0, word, 20, 1'b0);
      send_frame(1'b1, 16'($urandom), 20, 1'b0);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         tick();
         n++;
      end
      check(name, exp_q.size(), 0);
   endtask

   // Scoreboard monitor: every pop must match the oldest expected word
   always @(negedge clk) begin
      if (overflow) ovf_seen++;
      if (rts && rtr) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=%0h required=none", aud_out);
         end else begin
            check("sample", aud_out, exp_q.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      repeat (3) tick();
      check("reset_rts", rts, 0);
      check("reset_aud_out", aud_out, 0);
      check("reset_overflow", overflow, 0);
`ifdef AUDIO_RX_OVF_COUNT_EN
      check("reset_ovf_count", ovf_count, 0);
`endif
      rstb = 1'b1;
      tick();

      // 1: single left word with rtr held high; right word never presented
      rtr = 1'b1;
      send_frame(1'b1, 16'h0000, 20, 1'b0);
      send_frame(1'b0, 16'hA5C3, 20, 1'b0);
      send_frame(1'b1, 16'h1234, 20, 1'b0);
      drain("t1_drain");

      // 2: four buffered words, then consecutive pops
      rtr = 1'b0;
      for (int n = 1; n <= 4; n++) send_left(16'(n));
      check("t2_rts_full", rts, 1);
      check("t2_head", aud_out, 16'h0001);
      rtr = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         check("t2_rts_step", rts, 1);
         check("t2_aud_step", aud_out, n);
      end
      @(negedge clk);
      check("t2_rts_empty", rts, 0);
      tick();

      // 3: fifth word into a full FIFO is dropped
      rtr = 1'b0;
      for (int n = 1; n <= 4; n++) send_left(16'(n));
      send_left(16'hBEEF);
      check("t3_exp_ovf", exp_ovf, 1);
      check("t3_ovf_pulses", ovf_seen, exp_ovf);
      check("t3_head", aud_out, 16'h0001);
`ifdef AUDIO_RX_OVF_COUNT_EN
      check("t3_ovf_count", ovf_count, 1);
`endif
      rtr = 1'b1;
      drain("t3_drain");

      // 4: full FIFO with a pop in the push cycle keeps the new word
      rtr = 1'b0;
      for (int n = 1; n <= 4; n++) send_left(16'(n));
      send_frame(1'b0, 16'hBEEF, 20, 1'b1);
      send_frame(1'b1, 16'h0F0F, 20, 1'b0);
      check("t4_ovf_pulses", ovf_seen, exp_ovf);
      rtr = 1'b1;
      drain("t4_drain");

      // 5: short left frame is discarded
      send_frame(1'b0, 16'h1357, 12, 1'b0);
      send_frame(1'b1, 16'h2468, 20, 1'b0);
      send_left(16'h7FFF);
      drain("t5_drain");

      // 6: reset mid-frame with two words buffered
      rtr = 1'b0;
      send_left(16'h1111);
      send_left(16'h2222);
      send_frame(1'b0, 16'h3333, 8, 1'b0);
      rstb = 1'b0;
      #1;
      check("t6_rts_reset", rts, 0);
      check("t6_aud_reset", aud_out, 0);
      exp_q.delete();
      ws_hist.delete();
      sd_hist.delete();
      tick();
      tick();
      rstb = 1'b1;
      send_frame(1'b0, 16'h4444, 12, 1'b0);
      send_frame(1'b1, 16'h6666, 20, 1'b0);
      check("t6_rts_idle", rts, 0);
      send_left(16'h5A5A);
      check("t6_rts_after", rts, 1);
      rtr = 1'b1;
      drain("t6_drain");

      // Randomised frames, short frames and random rtr
      rand_rtr = 1'b1;
      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 3) == 0)
            send_frame(1'b0, 16'($urandom), $urandom_range(2, 17), 1'b0);
         else
            send_frame(1'b0, 16'($urandom), $urandom_range(18, 21), 1'b0);
         send_frame(1'b1, 16'($urandom), $urandom_range(18, 21), 1'b0);
      end
      rand_rtr = 1'b0;
      rtr = 1'b1;
      drain("rand_drain");
      check("final_ovf_pulses", ovf_seen, exp_ovf);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/audio_serial_rx.md
Name: audio_serial_rx

Overview:
Upstream feeder for the FIR filter state machine. Deserialises an I2S-format serial audio stream (sck/ws/sd) from the external codec, selects one channel, and buffers completed 16-bit samples in a small FIFO. Samples go to the filter over an rts/rtr handshake: this block drives rts and aud_out, and the filter drives rtr. Runs entirely in the clk domain. The serial inputs are oversampled.

Parameters:
WIDTH, 16, sample width in bits; also the aud_out width.
DEPTH, 4, FIFO depth in samples; must be a power of 2.
PTR, 2, log2(DEPTH); width of the FIFO pointers.
CH_SEL, 0, channel to keep: 0 = left (ws low), 1 = right (ws high).

Ports:
clk  in  1  system clock; must be at least 4x the sck frequency.
rstb  in  1  reset; asynchronous, active-low.
sck  in  1  serial bit clock from the codec; asynchronous to clk.
ws  in  1  word select; asynchronous to clk.
sd  in  1  serial data, MSB first; asynchronous to clk.
rtr  in  1  ready-to-receive from the filter.
rts  out  1  ready-to-send; high when the FIFO is not empty.
aud_out  out  WIDTH  FIFO head sample; valid while rts=1.
overflow  out  1  one-cycle pulse when a completed sample is dropped because the FIFO is full.

Behaviour:
- Synchronisation:
  - sck, ws and sd each pass through a 2-flop synchroniser.
  - sck_rise is a 1-cycle pulse when the synchronised sck goes 0->1.
  - All serial sampling happens only in sck_rise cycles.
- Word-select edge: in an sck_rise cycle, a ws edge means the synchronised ws differs from ws_q, the ws value captured at the previous sck_rise.
- State machine (one-hot). States are WAIT_WS, DELAY, SHIFT, HOLD.
  - WAIT_WS: entered on reset. On a ws edge where the new ws equals CH_SEL, go to DELAY. All other edges are ignored.
  - DELAY: the I2S one-bit delay. On the next sck_rise, go to SHIFT with bit_cnt=0.
  - SHIFT: on each sck_rise, shift sd into the LSB of shreg and increment bit_cnt.
    - When bit_cnt reaches WIDTH-1 and is shifted, assert push next cycle and go to HOLD.
    - If a ws edge occurs in SHIFT before WIDTH bits are captured (short frame), discard the partial word and go to WAIT_WS. The edge is then re-evaluated as in WAIT_WS in the same cycle, so a matching edge goes directly to DELAY.
  - HOLD: extra bits beyond WIDTH are ignored. On a ws edge, behave as in WAIT_WS.
- Latency:
  - The last bit is shifted in cycle N.
  - push is high in cycle N+1; the word is written at the end of N+1.
  - rts=1 and aud_out are valid from cycle N+2.
- FIFO:
  - DEPTH entries, with wr_ptr/rd_ptr of PTR bits plus an occupancy count of PTR+1 bits.
  - Pointers wrap modulo DEPTH.
  - Show-ahead: aud_out = mem[rd_ptr] whenever rts=1.
  - A pop occurs when rts && rtr at a clock edge. rd_ptr advances, and the next entry appears the following cycle.
  - rtr while empty has no effect.
  - Empty FIFO: a push becomes visible only after the write; there is no bypass.
- Full FIFO:
  - A push with no simultaneous pop drops the new sample. The FIFO contents are unchanged, and overflow pulses for 1 cycle, coincident with the write edge.
  - A push and pop in the same cycle while full both succeed; count stays DEPTH and there is no overflow.
- Simultaneous push and pop at any count: count is unchanged and both pointers advance.
- Reset:
  - rstb low asynchronously clears rts=0, aud_out=0, overflow=0, pointers and count to 0, shreg, bit_cnt, ws_q and all synchroniser flops to 0, and state to WAIT_WS.
  - A frame in progress is lost. The first sample after reset is taken only after a fresh matching ws edge.
- Width rule: samples are taken verbatim (two's complement). No sign extension or scaling.

Optional Feature:
Macro: AUDIO_RX_OVF_COUNT_EN.
- Defined: adds output ovf_count[7:0]. It is a saturating count of overflow pulses, cleared only by rstb, and holds at 8'hFF.
- Not defined: the port is absent. Only the overflow pulse exists.

Test Plan:
1. Left-channel word 16'hA5C3, rtr=1 held high (clk = 8x sck) -> a single rts pulse, aud_out=16'hA5C3 during it, popped the same cycle; the right-channel word 16'h1234 is never presented.
2. Four left words 16'h0001..16'h0004 with rtr=0 -> count=4 and rts=1 with aud_out=16'h0001. Then rtr=1 -> aud_out steps 0001, 0002, 0003, 0004 on consecutive cycles, then rts=0.
3. FIFO full (0001..0004), fifth word 16'hBEEF with rtr=0 -> overflow pulses once, aud_out stays 16'h0001, and BEEF is never output. With the macro defined, ovf_count=1.
4. FIFO full and rtr=1 exactly in the push cycle of 16'hBEEF -> no overflow; the output order is 0001, 0002, 0003, 0004, BEEF.
5. ws toggles after only 10 bits of a left frame, followed by a complete left frame 16'h7FFF -> the partial word is never pushed and the next sample output is 16'h7FFF.
6. rstb pulsed low mid-frame with 2 samples buffered -> rts=0 and aud_out=0 immediately. The resumed bitstream is ignored until the next matching ws edge, and the first complete word after that is output correctly.
